// File: rtl/recovery_ctrl.sv
// Lockstep rollback controller: on an analyzer mismatch it halts both cores, restores their
// register files from the checkpoint RF, reloads the last agreed PC, or goes fatal on repeats.
module recovery_ctrl #(
    parameter int unsigned NREGS        = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned DW           = 32,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [DW-1:0] BOOT_ADDR  = 32'h0000_0080
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          error_i,
    input  logic          commit_i,
    input  logic [DW-1:0] commit_pc_i,
    output logic          halt_o,
    output logic [AW-1:0] ckpt_raddr_o,
    input  logic [DW-1:0] ckpt_rdata_i,
    output logic          rf_we_o,
    output logic [AW-1:0] rf_waddr_o,
    output logic [DW-1:0] rf_wdata_o,
    output logic          pc_we_o,
    output logic [DW-1:0] pc_o,
    output logic          busy_o,
    output logic          fatal_o,
    output logic [15:0]   recov_cnt_o
);

    localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StRestore,
        StLoadPc,
        StResume,
        StFail
    } state_e;

    state_e          state_q, state_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [DW-1:0]   ckpt_pc_q, ckpt_pc_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   wdata_q;
    logic            pc_we_q, pc_we_d;
    logic [DW-1:0]   pc_q, pc_d;
    logic [15:0]     recov_q, recov_d;
    logic            halt_q, halt_d;
    logic            busy_q, busy_d;
    logic            fatal_q, fatal_d;

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        retry_d    = retry_q;
        ckpt_pc_d  = ckpt_pc_q;
        raddr_d    = raddr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        pc_we_d    = 1'b0;
        pc_d       = pc_q;
        recov_d    = recov_q;

        case (state_q)
            StIdle: begin
                if (error_i) begin
                    if (retry_q == RW'(MAX_RETRY)) begin
                        state_d = StFail;
                    end else begin
                        state_d = StDrain;
                        drain_d = DCW'(DRAIN_CYCLES - 1);
                    end
                end else if (commit_i) begin
                    ckpt_pc_d = commit_pc_i;
                    retry_d   = '0;
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StRestore;
                    raddr_d = AW'(1);
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StRestore: begin
                // raddr wraps to 0 after the last read; 0 then marks the restore as finished.
                if (raddr_q == '0) begin
                    state_d = StLoadPc;
                    pc_we_d = 1'b1;
                    pc_d    = ckpt_pc_q;
                end else begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = raddr_q;
                    raddr_d    = (raddr_q == AW'(NREGS - 1)) ? '0 : raddr_q + 1'b1;
                end
            end
            StLoadPc: begin
                state_d = StResume;
            end
            StResume: begin
                state_d = StIdle;
                if (retry_q != RW'(MAX_RETRY)) begin
                    retry_d = retry_q + 1'b1;
                end
                if (recov_q != 16'hFFFF) begin
                    recov_d = recov_q + 16'd1;
                end
            end
            StFail: begin
                state_d = StFail;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        halt_d  = (state_d != StIdle);
        busy_d  = halt_d && (state_d != StFail);
        fatal_d = (state_d == StFail);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            drain_q    <= '0;
            retry_q    <= '0;
            ckpt_pc_q  <= BOOT_ADDR;
            raddr_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            wdata_q    <= '0;
            pc_we_q    <= 1'b0;
            pc_q       <= BOOT_ADDR;
            recov_q    <= '0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            fatal_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            retry_q    <= retry_d;
            ckpt_pc_q  <= ckpt_pc_d;
            raddr_q    <= raddr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            if (rf_we_q) begin
                wdata_q <= ckpt_rdata_i;
            end
            pc_we_q    <= pc_we_d;
            pc_q       <= pc_d;
            recov_q    <= recov_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
            fatal_q    <= fatal_d;
        end
    end

    // The checkpoint RF output register is the write-data stage; wdata_q only holds it afterwards.
    assign rf_wdata_o   = rf_we_q ? ckpt_rdata_i : wdata_q;
    assign halt_o       = halt_q;
    assign ckpt_raddr_o = raddr_q;
    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign pc_we_o      = pc_we_q;
    assign pc_o         = pc_q;
    assign busy_o       = busy_q;
    assign fatal_o      = fatal_q;
    assign recov_cnt_o  = recov_q;

endmodule
